// File: rtl/tqv_reg_bus_arbiter.sv
// Two-requester round-robin arbiter in front of one TinyQV peripheral register port.
// One transaction in flight; reads wait for data_ready with a timeout and return width-masked data.

module tqv_reg_bus_req_dec (
  input  logic [1:0] wr_n_i,
  input  logic [1:0] rd_n_i,
  output logic       act_o,
  output logic       wr_o
);
  // A write strobe takes priority over a simultaneous read strobe.
  assign wr_o  = (wr_n_i != 2'b11);
  assign act_o = wr_o || (rd_n_i != 2'b11);
endmodule

module tqv_reg_bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  req_addr_0,
  input  logic [31:0] req_wdata_0,
  input  logic [1:0]  req_write_n_0,
  input  logic [1:0]  req_read_n_0,
  output logic        done_0,
  output logic        err_0,
  input  logic [5:0]  req_addr_1,
  input  logic [31:0] req_wdata_1,
  input  logic [1:0]  req_write_n_1,
  input  logic [1:0]  req_read_n_1,
  output logic        done_1,
  output logic        err_1,
  output logic [31:0] rdata,
  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready
);

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  wr_n;
    logic [1:0]  rd_n;
  } req_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  req_t [1:0] req;
  logic [1:0] act, is_wr;

  assign req[0] = {req_addr_0, req_wdata_0, req_write_n_0, req_read_n_0};
  assign req[1] = {req_addr_1, req_wdata_1, req_write_n_1, req_read_n_1};

  generate
    for (genvar k = 0; k < 2; k++) begin : g_dec
      tqv_reg_bus_req_dec u_dec (
        .wr_n_i (req[k].wr_n),
        .rd_n_i (req[k].rd_n),
        .act_o  (act[k]),
        .wr_o   (is_wr[k])
      );
    end
  endgenerate

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [1:0]        wn_q, wn_d;
  logic [1:0]        rn_q, rn_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              gnt;
  logic [31:0]       rd_masked;

  // On contention the requester that was not served last wins.
  always_comb begin
    gnt = act[1];
    if (act == 2'b11) gnt = ~last_q;
  end

  always_comb begin
    rd_masked = data_out;
    case (rn_q)
      2'b00:   rd_masked = {24'b0, data_out[7:0]};
      2'b01:   rd_masked = {16'b0, data_out[15:0]};
      default: rd_masked = data_out;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wn_d    = wn_q;
    rn_d    = rn_q;
    rdata_d = rdata_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (|act) begin
          last_d = gnt;
          addr_d = req[gnt].addr;
          cnt_d  = '0;
          if (is_wr[gnt]) begin
            din_d        = req[gnt].wdata;
            wn_d         = req[gnt].wr_n;
            done_d[gnt]  = 1'b1;
            state_d      = WRITE;
          end else begin
            rn_d    = req[gnt].rd_n;
            state_d = READ;
          end
        end
      end
      WRITE: begin
        wn_d    = 2'b11;
        state_d = IDLE;
      end
      READ: begin
        if (data_ready) begin
          rdata_d        = rd_masked;
          rn_d           = 2'b11;
          done_d[last_q] = 1'b1;
          state_d        = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d        = '0;
          rn_d           = 2'b11;
          done_d[last_q] = 1'b1;
          err_d[last_q]  = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wn_q    <= 2'b11;
      rn_q    <= 2'b11;
      rdata_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wn_q    <= wn_d;
      rn_q    <= rn_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign done_0       = done_q[0];
  assign done_1       = done_q[1];
  assign err_0        = err_q[0];
  assign err_1        = err_q[1];
  assign rdata        = rdata_q;
  assign address      = addr_q;
  assign data_in      = din_q;
  assign data_write_n = wn_q;
  assign data_read_n  = rn_q;

endmodule

// File: tb/tb_tqv_reg_bus_arbiter.sv
// Directed bench for tqv_reg_bus_arbiter: per-requester stimulus queues, a scoreboard of
// expected completions, and a peripheral model that answers reads by address.

module tb_tqv_reg_bus_arbiter;
  localparam int TO = 64;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  w;
    int          delay;
    int          lat;
    int          t0;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  req_addr_0, req_addr_1;
  logic [31:0] req_wdata_0, req_wdata_1;
  logic [1:0]  req_write_n_0, req_write_n_1, req_read_n_0, req_read_n_1;
  logic        done_0, done_1, err_0, err_1;
  logic [31:0] rdata, data_in, data_out;
  logic [5:0]  address;
  logic [1:0]  data_write_n, data_read_n;
  logic        data_ready;

  always #5 clk = ~clk;

  tqv_reg_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .req_write_n_0(req_write_n_0), .req_read_n_0(req_read_n_0),
    .done_0(done_0), .err_0(err_0),
    .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .req_write_n_1(req_write_n_1), .req_read_n_1(req_read_n_1),
    .done_1(done_1), .err_1(err_1),
    .rdata(rdata), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready)
  );

  int   n_chk = 0, n_fail = 0, cyc = 0, rd_len = 0;
  txn_t stim0[$], stim1[$], exp0[$], exp1[$];
  int   order[$];
  bit   active[2], done_seen[2];
  logic [31:0] mem_data [64];
  int          mem_dly  [64];

  function automatic logic [31:0] mask(logic [31:0] d, logic [1:0] w);
    case (w)
      2'b00:   return d & 32'h0000_00FF;
      2'b01:   return d & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  function automatic txn_t mk(bit wr, logic [5:0] a, logic [31:0] d, logic [1:0] w, int dly, int lat);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d; t.w = w; t.delay = dly; t.lat = lat; t.t0 = 0;
    return t;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic set_idle(int k);
    if (k == 0) begin
      req_addr_0 = '0; req_wdata_0 = '0; req_write_n_0 = 2'b11; req_read_n_0 = 2'b11;
    end else begin
      req_addr_1 = '0; req_wdata_1 = '0; req_write_n_1 = 2'b11; req_read_n_1 = 2'b11;
    end
  endtask

  // Writes also drive a read width so that write priority is exercised.
  task automatic set_req(int k, txn_t t);
    if (k == 0) begin
      req_addr_0 = t.addr; req_wdata_0 = t.wr ? t.data : 32'hFFFF_FFFF;
      req_write_n_0 = t.wr ? t.w : 2'b11; req_read_n_0 = t.wr ? 2'b01 : t.w;
    end else begin
      req_addr_1 = t.addr; req_wdata_1 = t.wr ? t.data : 32'hFFFF_FFFF;
      req_write_n_1 = t.wr ? t.w : 2'b11; req_read_n_1 = t.wr ? 2'b00 : t.w;
    end
  endtask

  task automatic sample();
    txn_t e;
    int   k, n;
    cyc++;
    if (data_read_n !== 2'b11) rd_len++;
    if (data_write_n !== 2'b11) chk("wstrobe_with_done", 32'(done_0 | done_1), 32'd1);
    if (done_0 === 1'b1 || done_1 === 1'b1) begin
      chk("single_done", 32'(done_0 & done_1), 32'd0);
      k = (done_1 === 1'b1) ? 1 : 0;
      order.push_back(k);
      done_seen[k] = 1'b1;
      n = (k == 0) ? exp0.size() : exp1.size();
      chk("done_expected", 32'(n), 32'd1);
      if (n > 0) begin
        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        chk("err", 32'({err_1, err_0}), 32'((!e.wr && e.delay < 0) ? (1 << k) : 0));
        chk("address", 32'(address), 32'(e.addr));
        chk("data_read_n_idle", 32'(data_read_n), 32'd3);
        if (e.wr) begin
          chk("data_write_n", 32'(data_write_n), 32'(e.w));
          chk("data_in", data_in, e.data);
        end else begin
          chk("rdata", rdata, (e.delay < 0) ? 32'd0 : mask(e.data, e.w));
          chk("rd_strobe_len", 32'(rd_len), 32'((e.delay < 0) ? TO : e.delay + 1));
          rd_len = 0;
        end
        if (e.lat >= 0) chk("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  endtask

  task automatic drive();
    txn_t t;
    for (int k = 0; k < 2; k++) begin
      if (done_seen[k]) begin
        done_seen[k] = 1'b0; active[k] = 1'b0; set_idle(k);
      end
      if (!active[k] && ((k == 0) ? stim0.size() : stim1.size()) > 0) begin
        t = (k == 0) ? stim0.pop_front() : stim1.pop_front();
        t.t0 = cyc + 1;
        if (!t.wr) begin mem_data[t.addr] = t.data; mem_dly[t.addr] = t.delay; end
        set_req(k, t);
        if (k == 0) exp0.push_back(t); else exp1.push_back(t);
        active[k] = 1'b1;
      end
    end
    // Ready is held high outside reads; the arbiter must ignore it there.
    if (data_read_n !== 2'b11) begin
      data_out   = mem_data[address];
      data_ready = (mem_dly[address] >= 0) && (rd_len == mem_dly[address]);
    end else begin
      data_out   = 32'hDEAD_BEEF;
      data_ready = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(int max);
    int n = 0;
    while ((stim0.size() > 0 || stim1.size() > 0 || active[0] || active[1]) && n < max) begin
      cycle();
      n++;
    end
    n_chk++;
    assert (n < max) else begin
      n_fail++;
      $error("FAIL run_bound: observed %0d cycles expected fewer than %0d", n, max);
    end
  endtask

  task automatic chk_order(int n, int pat);
    chk("order_len", 32'(order.size()), 32'(n));
    for (int i = 0; i < n && i < order.size(); i++)
      chk("grant_order", 32'(order[i]), 32'((pat >> i) & 1));
    order.delete();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_address"}, 32'(address), 32'd0);
    chk({tag, "_data_in"}, data_in, 32'd0);
    chk({tag, "_write_n"}, 32'(data_write_n), 32'd3);
    chk({tag, "_read_n"}, 32'(data_read_n), 32'd3);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_done"}, 32'({done_1, done_0}), 32'd0);
    chk({tag, "_err"}, 32'({err_1, err_0}), 32'd0);
  endtask

  initial begin
    set_idle(0); set_idle(1);
    data_out = '0; data_ready = 1'b0;
    active[0] = 0; active[1] = 0; done_seen[0] = 0; done_seen[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Uncontended 32-bit write: strobe one cycle after the request.
    stim0.push_back(mk(1, 6'h05, 32'h1234_5678, 2'b10, 0, 1));
    run(20);
    chk_order(1, 0);

    // 8-bit read, ready on the third strobe cycle.
    stim1.push_back(mk(0, 6'h10, 32'hAABB_CCDD, 2'b00, 2, 4));
    run(20);
    chk_order(1, 1);

    // Both sides writing back to back must alternate.
    stim0.push_back(mk(1, 6'h01, 32'h1111_1111, 2'b00, 0, -1));
    stim0.push_back(mk(1, 6'h02, 32'h2222_2222, 2'b10, 0, -1));
    stim1.push_back(mk(1, 6'h03, 32'h3333_3333, 2'b01, 0, -1));
    stim1.push_back(mk(1, 6'h04, 32'h4444_4444, 2'b10, 0, -1));
    run(40);
    chk_order(4, 4'b1010);

    // Read that never sees ready times out, then the waiting writer is served.
    stim0.push_back(mk(0, 6'h20, 32'h5566_7788, 2'b10, -1, TO + 1));
    stim1.push_back(mk(1, 6'h21, 32'h9999_AAAA, 2'b10, 0, -1));
    run(200);
    chk_order(2, 2'b10);

    // 16-bit read with same-cycle ready: three cycles end to end.
    stim0.push_back(mk(0, 6'h08, 32'hFFFF_1234, 2'b01, 0, 2));
    run(20);
    chk_order(1, 0);

    // Asynchronous reset in the middle of a read.
    stim1.push_back(mk(0, 6'h30, 32'hCAFE_F00D, 2'b10, -1, -1));
    repeat (6) cycle();
    chk("in_read_before_reset", 32'(data_read_n), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    stim0.delete(); stim1.delete(); exp0.delete(); exp1.delete(); order.delete();
    active[0] = 0; active[1] = 0; done_seen[0] = 0; done_seen[1] = 0;
    set_idle(0); set_idle(1);
    rd_len = 0;
    repeat (3) cycle();
    chk_order(0, 0);
    rst = 1'b0;
    stim0.push_back(mk(1, 6'h3A, 32'h0BAD_F00D, 2'b10, 0, 1));
    stim1.push_back(mk(1, 6'h3B, 32'h1357_9BDF, 2'b01, 0, -1));
    run(20);
    chk_order(2, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tqv_reg_bus_arbiter.md
Name: tqv_reg_bus_arbiter

Overview:
Shares one TinyQV peripheral register port (6-bit address, 32-bit data, 2-bit write/read width strobes, data_ready) between two requesters: requester 0 (SPI host bridge) and requester 1 (on-chip sequencer/DMA).
- Round-robin arbitration; one transaction in flight at a time.
- Read wait with a timeout, and width-masked read data return.
- Sits between the requesters and the peripheral under test.

Parameters:
TIMEOUT, 64, max cycles a read strobe is held waiting for data_ready before abort (2..255)
CNT_W, 8, width of timeout counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_addr_0  input  6  requester 0 register address
req_wdata_0  input  32  requester 0 write data
req_write_n_0  input  2  requester 0 write width: 00=8b, 01=16b, 10=32b, 11=none
req_read_n_0  input  2  requester 0 read width, same encoding
done_0  output  1  one-cycle completion pulse to requester 0
err_0  output  1  valid with done_0: read timed out
req_addr_1, req_wdata_1, req_write_n_1, req_read_n_1, done_1, err_1  (same as requester 0, for requester 1)
rdata  output  32  read data, valid in the done cycle, shared by both requesters
address  output  6  to peripheral
data_in  output  32  to peripheral (write data)
data_write_n  output  2  to peripheral
data_read_n  output  2  to peripheral
data_out  input  32  from peripheral
data_ready  input  1  from peripheral, read data valid

Behaviour:
- Request: requester k is requesting when req_write_n_k != 11 or req_read_n_k != 11.
  - If both write_n and read_n are != 11, the request is a write; read_n is ignored.
  - A requester holds its inputs stable until it sees done_k, then deasserts in the next cycle.
- Reset: state=IDLE, last=1 (so requester 0 wins first), cnt=0.
  - Reset values: address=0, data_in=0, data_write_n=11, data_read_n=11, rdata=0, done_*=0, err_*=0.
  - Reset mid-transaction aborts it immediately; no done is issued.
- All peripheral-side outputs are registered.
- IDLE:
  - If exactly one requester is requesting, grant it.
  - If both are requesting, grant the one != last.
  - On grant: latch address/data/width into output registers, set last=granted requester.
  - Next state: WRITE for a write, READ for a read. No request: stay in IDLE.
- WRITE (exactly 1 cycle):
  - data_write_n = latched width; done_g=1, err_g=0.
  - Next state: IDLE with data_write_n=11.
  - Request-to-strobe latency is 1 cycle.
- READ:
  - data_read_n = latched width held every cycle; cnt increments.
  - data_ready sampled 1 (including the first READ cycle): capture masked data_out into rdata -> RESP.
  - cnt reaches TIMEOUT-1 without data_ready: rdata=0, set err flag -> RESP.
- RESP (1 cycle):
  - data_read_n=11; done_g=1; err_g = timeout flag.
  - Then IDLE, clear cnt and the timeout flag.
- Read masking:
  - Width 00: rdata[31:8]=0.
  - Width 01: rdata[31:16]=0.
  - Width 10: full 32 bits.
- Minimum occupancy: write = IDLE+WRITE = 2 cycles; read = 3 cycles with ready in the first READ cycle.
- IDLE is always visited between transactions. Back-to-back requests from both sides alternate 0,1,0,1.
- The non-granted requester waits with no done; its request persists and is served next.
- data_ready outside READ is ignored. done_0 and done_1 are never high together.
- data_in holds the last write data when not writing; it is don't-care to the peripheral.

Test Plan:
- After reset, requester 0 writes addr 0x05, data 0x12345678, width 10 -> one cycle later data_write_n=10, address=0x05, data_in=0x12345678 for exactly 1 cycle; done_0=1 that cycle, err_0=0.
- Requester 1 reads addr 0x10, width 00; peripheral returns data_out=0xAABBCCDD with data_ready 2 cycles after the strobe -> data_read_n=00 held 3 cycles; next cycle done_1=1, rdata=0x000000DD.
- Both requesters issue writes continuously for 4 transactions -> grant order 0,1,0,1; never two done pulses in one cycle.
- Read with data_ready never asserted, TIMEOUT=64 -> data_read_n held 64 cycles; then done=1, err=1, rdata=0; the arbiter then serves the pending other requester.
- Assert rst while in READ -> all outputs at reset values immediately (async); no done pulse. After release, requester 0 wins the first grant.
- 16-bit read of data_out=0xFFFF1234 with same-cycle data_ready -> rdata=0x00001234; 3-cycle total occupancy.
